// File: rtl/hop_scan_ctrl.sv
// Serial scan-chain loader: shifts one hop's IF configuration word into the tag chip
// using a two-phase non-overlapping scan clock. Define SCAN_LSB_FIRST_EN for LSB-first shifting.
module hop_scan_ctrl #(
  parameter int SCAN_WIDTH    = 2,
  parameter int NTX_BITS      = 78,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TX_BITS_WIDTH-1:0] data_in,
  output logic                     scan_id,
  output logic                     scan_phi,
  output logic                     scan_phi_bar,
  output logic                     scan_data_in,
  output logic                     scan_load_chip,
  output logic [BIT_CNT_WIDTH-1:0] nbits_cnt
);

  localparam int PH_W = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_START, S_DATA, S_PHI, S_GAP, S_PHI_BAR, S_LGAP, S_LOAD, S_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [PH_W-1:0]          r_ph, w_ph_nxt;
  logic [NTX_BITS-1:0]      r_shift, w_shift_nxt, w_capture;
  logic [BIT_CNT_WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                     w_ph_last;
  logic                     r_id, r_phi, r_phi_bar, r_data, r_load;
  logic                     w_id, w_phi, w_phi_bar, w_data, w_load;
  logic                     w_unused_upper;

  // Only data_in[N-1:0] is shifted; the remaining bits are deliberately ignored.
  assign w_unused_upper = ^data_in;

  // The shifter always emits its MSB, so LSB-first mode reverses the word at capture.
  always_comb begin
    w_capture = '0;
    for (int i = 0; i < NTX_BITS; i++) begin
`ifdef SCAN_LSB_FIRST_EN
      w_capture[NTX_BITS-1-i] = data_in[i];
`else
      w_capture[i] = data_in[i];
`endif
    end
  end

  assign w_ph_last = (r_ph == PH_W'(SCAN_WIDTH - 1));
  assign w_cnt_inc = r_cnt + BIT_CNT_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_START: begin
        w_state_nxt = S_DATA;
        w_ph_nxt    = '0;
        w_shift_nxt = w_capture;
        w_cnt_nxt   = '0;
      end
      S_DATA, S_PHI, S_GAP, S_LGAP, S_LOAD: begin
        if (w_ph_last) begin
          w_ph_nxt = '0;
          unique case (r_state)
            S_DATA:  w_state_nxt = S_PHI;
            S_PHI:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_PHI_BAR;
            S_LGAP:  w_state_nxt = S_LOAD;
            default: w_state_nxt = S_DONE;
          endcase
        end else begin
          w_ph_nxt = r_ph + PH_W'(1);
        end
      end
      S_PHI_BAR: begin
        if (w_ph_last) begin
          w_ph_nxt    = '0;
          w_cnt_nxt   = w_cnt_inc;
          w_shift_nxt = r_shift << 1;
          w_state_nxt = (w_cnt_inc < BIT_CNT_WIDTH'(NTX_BITS)) ? S_DATA : S_LGAP;
        end else begin
          w_ph_nxt = r_ph + PH_W'(1);
        end
      end
      default: w_state_nxt = S_DONE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_id      = (w_state_nxt != S_START) && (w_state_nxt != S_DONE);
    w_phi     = (w_state_nxt == S_PHI);
    w_phi_bar = (w_state_nxt == S_PHI_BAR);
    w_load    = (w_state_nxt == S_LOAD);
    w_data    = 1'b0;
    if ((w_state_nxt == S_DATA) || (w_state_nxt == S_PHI) ||
        (w_state_nxt == S_GAP)  || (w_state_nxt == S_PHI_BAR))
      w_data = w_shift_nxt[NTX_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_START;
      r_ph      <= '0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_id      <= 1'b0;
      r_phi     <= 1'b0;
      r_phi_bar <= 1'b0;
      r_data    <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ph      <= w_ph_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_id      <= w_id;
      r_phi     <= w_phi;
      r_phi_bar <= w_phi_bar;
      r_data    <= w_data;
      r_load    <= w_load;
    end
  end

  assign scan_id        = r_id;
  assign scan_phi       = r_phi;
  assign scan_phi_bar   = r_phi_bar;
  assign scan_data_in   = r_data;
  assign scan_load_chip = r_load;
  assign nbits_cnt      = r_cnt;

endmodule

// File: tb/tb_hop_scan_ctrl.sv
// Directed bench for hop_scan_ctrl: compares every output on every edge against a timing
// model built from the edge schedule, and reconstructs the shifted word at phi rising edges.
module tb_hop_scan_ctrl;

  localparam int W   = 2;
  localparam int N   = 78;
  localparam int TXW = 128;
  localparam int CW  = 7;
  localparam int TOT = 4 * W * N;
  localparam int RUN = TOT + 2 * W + 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [TXW-1:0] data_in = '0;
  logic           scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip;
  logic [CW-1:0]  nbits_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hop_scan_ctrl #(
    .SCAN_WIDTH(W), .NTX_BITS(N), .TX_BITS_WIDTH(TXW), .BIT_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .scan_id(scan_id), .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar),
    .scan_data_in(scan_data_in), .scan_load_chip(scan_load_chip),
    .nbits_cnt(nbits_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed as {id, phi, phi_bar, data, load, cnt[6:0]}.
  function automatic logic [11:0] exp_out(input logic [TXW-1:0] cap, input int e);
    int   k, ph;
    logic b;
    if (e <= TOT) begin
      k  = (e - 1) / (4 * W);
      ph = ((e - 1) % (4 * W)) / W;
`ifdef SCAN_LSB_FIRST_EN
      b = cap[k];
`else
      b = cap[N-1-k];
`endif
      return {1'b1, ph == 1, ph == 3, b, 1'b0, CW'(k)};
    end else if (e <= TOT + W) begin
      return {5'b10000, CW'(N)};
    end else if (e <= TOT + 2 * W) begin
      return {5'b10001, CW'(N)};
    end
    return {5'b00000, CW'(N)};
  endfunction

  function automatic logic [11:0] obs();
    return {scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, nbits_cnt};
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_out[%0d]", i), obs(), 12'h000);
    end
  endtask

  task automatic run_seq(input logic [TXW-1:0] cap, input int n_edges, input int chg_at,
                         input logic [TXW-1:0] chg_val, input logic full_chk);
    int           phi_n = 0, pb_n = 0, ovl = 0;
    logic         prev_phi = 1'b0, prev_pb = 1'b0;
    logic [N-1:0] rec = '0;
    data_in = cap;
    reset   = 1'b0;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == chg_at) data_in = chg_val;
      @(posedge clk); #1;
      check($sformatf("out@%0d", e), obs(), exp_out(cap, e));
      if (scan_phi && !prev_phi) begin
        phi_n++;
`ifdef SCAN_LSB_FIRST_EN
        rec = {scan_data_in, rec[N-1:1]};
`else
        rec = {rec[N-2:0], scan_data_in};
`endif
      end
      if (scan_phi_bar && !prev_pb) pb_n++;
      if (scan_phi && scan_phi_bar) ovl++;
      prev_phi = scan_phi;
      prev_pb  = scan_phi_bar;
    end
    check("phi_overlap", ovl, 0);
    if (full_chk) begin
      check("phi_pulses", phi_n, N);
      check("phi_bar_pulses", pb_n, N);
      check("reconstructed", rec, cap[N-1:0]);
    end
  endtask

  initial begin
    logic [TXW-1:0] alt, cap_c, cap_d1, cap_d2;
    alt    = {{(TXW-N){1'b1}}, {(N/2){2'b10}}};
    cap_c  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    cap_d1 = 128'h0000_0000_0000_2A5C_3F0F_00FF_A5A5_1E2D;
    cap_d2 = 128'hFFFF_0000_0000_1B3C_96E1_C0DE_F00D_7777;

    do_reset(2);
    run_seq('0, RUN, 0, '0, 1'b1);

    do_reset(1);
    run_seq(alt, RUN, 0, '0, 1'b1);

    do_reset(4);
    run_seq(cap_c, RUN, 50, ~cap_c, 1'b1);

    do_reset(1);
    run_seq(cap_d1, 299, 0, '0, 1'b0);
    do_reset(3);
    run_seq(cap_d2, RUN, 0, '0, 1'b1);

    do_reset(1);
    run_seq(128'h1, RUN, 0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hop_scan_ctrl.md
# hop_scan_ctrl

Serial scan-chain loader that shifts one hop's IF configuration word into the tag chip. It generates a two-phase non-overlapping scan clock (phi/phi_bar), a scan data bit, a scan-enable ID and a final load strobe. It runs on the divided scan clock in the tag RX controller. The RX controller restarts it for every frequency hop by pulsing its reset.

## Interface
- SCAN_WIDTH, 2: cycles per scan phase (W); ≥1.
- NTX_BITS, 78: bits shifted per load (N); N ≤ TX_BITS_WIDTH and N < 2^BIT_CNT_WIDTH.
- TX_BITS_WIDTH, 128: width of data_in.
- BIT_CNT_WIDTH, 7: width of nbits_cnt.

Ports:
- clk  in  1  scan clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- data_in  in  TX_BITS_WIDTH  configuration word; bits [N-1:0] are used, upper bits are ignored.
- scan_id  out  1  scan-mode enable to the chip.
- scan_phi  out  1  scan clock phase 1.
- scan_phi_bar  out  1  scan clock phase 2.
- scan_data_in  out  1  serial data bit.
- scan_load_chip  out  1  parallel-load strobe.
- nbits_cnt  out  BIT_CNT_WIDTH  number of bits fully shifted.

## Operation
- All outputs are registered. While reset is high, every output is 0 and the FSM is in START.
- START: on the first edge with reset low, capture data_in[N-1:0] into the internal shift register. Go to DATA for bit 0.
- Per bit, four phases, each lasting W cycles:
  - DATA: scan_data_in = current bit, phi = 0, phi_bar = 0.
  - PHI: phi = 1.
  - GAP: both phases 0.
  - PHI_BAR: phi_bar = 1.
- scan_data_in holds the current bit through all four phases.
- At the end of PHI_BAR, nbits_cnt increments. If nbits_cnt < N, go to DATA for the next bit. Otherwise go to LGAP.
- LGAP: W cycles with all strobes low and scan_data_in = 0.
- LOAD: scan_load_chip = 1 for W cycles.
- DONE: all outputs 0 except nbits_cnt, which holds N. The FSM stays in DONE until reset.
- scan_id is 1 from the first DATA cycle through the last LOAD cycle, and 0 in START and DONE.
- Bit order is MSB-first: data_in[N-1] first, data_in[0] last.
- Because data_in is captured once, later changes to data_in have no effect until the next reset.
- phi and phi_bar are never high in the same cycle.

## Timing
- Edge n means the n-th rising edge with reset sampled low. Output values are those after that edge.
- Bit k (0-based) phases:
  - DATA: edges 1+4Wk … W+4Wk.
  - PHI: next W edges.
  - GAP: next W edges.
  - PHI_BAR: next W edges.
- nbits_cnt becomes k+1 at edge 4W(k+1)+1.
- LGAP: edges 4WN+1 … 4WN+W.
- LOAD: edges 4WN+W+1 … 4WN+2W.
- DONE from edge 4WN+2W+1.
- Defaults (W=2, N=78):
  - bit k DATA at edges 1+8k, 2+8k; PHI at 3+8k, 4+8k; PHI_BAR at 7+8k, 8+8k.
  - nbits_cnt = 78 at edge 625.
  - scan_load_chip high at edges 627–628.
  - DONE at edge 629.
- Reset mid-operation: outputs are 0 on the edge after reset is sampled high. The sequence restarts from START, with a fresh data_in capture, when reset falls.
- Reset held high for multiple cycles behaves identically to a single-cycle reset.

## Configuration
- Macro SCAN_LSB_FIRST_EN:
  - Defined: bits shift LSB-first, data_in[0] first and data_in[N-1] last.
  - Undefined (default): MSB-first as specified above.
- Timing is identical in both modes.

## Test plan
- Reset, then data_in = 0, defaults:
  - scan_data_in is 0 throughout.
  - 78 phi pulses and 78 phi_bar pulses, each 2 cycles wide.
  - load high at edges 627–628.
  - nbits_cnt = 78 at edge 625 and holds afterwards.
- data_in[77:0] = alternating 1,0 starting with bit 77 = 1: scan_data_in = 1 during bit 0 (edges 1–8) and 0 during bit 1 (edges 9–16). Sampling scan_data_in at each phi rising edge reconstructs data_in[77:0].
- data_in changes at edge 50: the shifted bits still equal the value captured at edge 1.
- Reset asserted at edge 300, released 3 cycles later:
  - all outputs are 0 while reset is high.
  - the sequence restarts with bit 0 DATA and nbits_cnt = 0.
- Every cycle: assert !(phi && phi_bar). Assert scan_id = 1 exactly from edge 1 through edge 628 and 0 afterwards.
- With SCAN_LSB_FIRST_EN and data_in = 1: scan_data_in = 1 only during bit 0 (edges 1–8).
